// File: rtl/spi_mem_ctrl_pkg.sv
// spi_mem_ctrl_pkg: shared SPI command codes, access sizes and controller states
package spi_mem_ctrl_pkg;
  localparam logic [7:0] SPI_CMD_READ  = 8'h03;
  localparam logic [7:0] SPI_CMD_WRITE = 8'h02;
  localparam logic [1:0] MEM_SIZE_B = 2'd0;
  localparam logic [1:0] MEM_SIZE_H = 2'd1;
  localparam logic [1:0] MEM_SIZE_W = 2'd2;
  typedef enum logic [1:0] {IDLE, SHIFT, GUARD} state_e;
endpackage

// File: rtl/spi_sck_gen.sv
// spi_sck_gen: divides clk into a mode-0 SCK with one-cycle rise/fall strobes
module spi_sck_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic sck,
  output logic rise_strobe,
  output logic fall_strobe
);
  localparam int DW = $clog2(CLK_DIV + 1);
  logic [DW-1:0] div_q;
  logic          sck_q;
  logic          wrap;
  assign wrap        = enable && div_q == DW'(CLK_DIV - 1);
  assign rise_strobe = wrap && !sck_q;
  assign fall_strobe = wrap && sck_q;
  assign sck         = sck_q;
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      div_q <= '0;
      sck_q <= 1'b0;
    end else begin
      div_q <= wrap ? '0 : div_q + 1'b1;
      sck_q <= sck_q ^ wrap;
    end
  end
endmodule

// File: rtl/spi_mem_ctrl.sv
// spi_mem_ctrl: bridges CPU mem_ce requests to an SPI serial RAM (READ/WRITE, 24-bit address)
module spi_mem_ctrl
  import spi_mem_ctrl_pkg::*;
#(
  parameter int          CLK_DIV   = 2,
  parameter int unsigned MEM_BYTES = 131072
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_ce,
  input  logic        mem_we,
  input  logic [1:0]  mem_size,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_busy,
  output logic        mem_valid,
  output logic        mem_fault,
  output logic        spi_cs_n,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso
);
  localparam int GW = $clog2(2 * CLK_DIV + 1);
  state_e        state_q;
  logic          armed_q, we_q, busy_q, valid_q, fault_q, cs_n_q, mosi_q;
  logic [5:0]    bit_q, last_q;
  logic [63:0]   tx_q;
  logic [31:0]   rdata_q;
  logic [GW-1:0] guard_q;
  logic          sck_rise, sck_fall, done, out_of_range;
  logic [63:0]   frame_d;
  logic [5:0]    last_d;
  // Data bytes go out in ascending address order, so wdata byte0 leads.
  always_comb begin
    out_of_range = mem_addr >= 32'(MEM_BYTES);
    frame_d = {mem_we ? SPI_CMD_WRITE : SPI_CMD_READ, mem_addr[23:0],
               mem_we ? {mem_wdata[7:0], mem_wdata[15:8], mem_wdata[23:16], mem_wdata[31:24]} : 32'h0};
    last_d = mem_size == MEM_SIZE_B ? 6'd39 : mem_size == MEM_SIZE_H ? 6'd47 : 6'd63;
    done = sck_fall && bit_q == last_q;
  end
  spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck (
    .clk         (clk),
    .reset       (reset),
    .enable      (state_q == SHIFT),
    .sck         (spi_sck),
    .rise_strobe (sck_rise),
    .fall_strobe (sck_fall)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      armed_q <= 1'b1;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      cs_n_q  <= 1'b1;
      mosi_q  <= 1'b0;
      bit_q   <= '0;
      last_q  <= '0;
      tx_q    <= '0;
      rdata_q <= '0;
      guard_q <= '0;
    end else begin
      if (mem_ce) begin
        armed_q <= 1'b1;
        fault_q <= 1'b0;
      end
      case (state_q)
        IDLE: if (armed_q && !mem_ce) begin
          armed_q <= 1'b0;
          if (out_of_range) fault_q <= 1'b1;
          else begin
            state_q <= SHIFT;
            busy_q  <= 1'b1;
            valid_q <= 1'b0;
            cs_n_q  <= 1'b0;
            we_q    <= mem_we;
            last_q  <= last_d;
            bit_q   <= '0;
            tx_q    <= {frame_d[62:0], 1'b0};
            mosi_q  <= frame_d[63];
            if (!mem_we) rdata_q <= '0;
          end
        end
        SHIFT: begin
          // Bit 32+j lands in byte j>>3, MSB-first within the byte.
          if (sck_rise && !we_q && bit_q[5]) rdata_q[{bit_q[4:3], ~bit_q[2:0]}] <= spi_miso;
          if (done) begin
            state_q <= GUARD;
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
            cs_n_q  <= 1'b1;
            mosi_q  <= 1'b0;
            guard_q <= '0;
          end else if (sck_fall) begin
            bit_q  <= bit_q + 6'd1;
            mosi_q <= tx_q[63];
            tx_q   <= {tx_q[62:0], 1'b0};
          end
        end
        default: begin
          guard_q <= guard_q + 1'b1;
          if (guard_q == GW'(2 * CLK_DIV - 1)) state_q <= IDLE;
        end
      endcase
    end
  end
  assign mem_rdata = rdata_q;
  assign mem_busy  = busy_q;
  assign mem_valid = valid_q;
  assign mem_fault = fault_q;
  assign spi_cs_n  = cs_n_q;
  assign spi_mosi  = mosi_q;
endmodule
